// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ram_loader
//  Description : Streams program words from a valid/ready source into the
//                SAP-1 16x8 program RAM. The words are written one after
//                another, starting at address 0. The CPU is held off through
//                busy while a session runs.
//  Revision    : 1.0  initial release
// ============================================================================
module ram_loader #(
    parameter int WordSize    = 8,
    parameter int AddressSize = 4
) (
    input  logic                   CLK,
    input  logic                   CLR,
    input  logic                   start,
    input  logic [WordSize-1:0]    in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [AddressSize-1:0] RAM_address,
    output logic [WordSize-1:0]    RAM_data,
    output logic                   WE_bar,
    output logic                   busy,
    output logic                   done,
    output logic [AddressSize:0]   word_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AddressSize-1:0] c_addr_max  = '1;
    localparam logic [AddressSize-1:0] c_addr_zero = '0;
    localparam logic [AddressSize-1:0] c_addr_one  = {{(AddressSize-1){1'b0}}, 1'b1};
    localparam logic [AddressSize:0]   c_count_one = {{AddressSize{1'b0}}, 1'b1};

    state_t                 r_state, w_state_next;
    logic [AddressSize-1:0] r_addr,  w_addr_next;
    logic [WordSize-1:0]    r_data,  w_data_next;
    logic                   r_last,  w_last_next;
    logic [AddressSize:0]   r_count, w_count_next;

    // State and datapath registers. The asynchronous clear forces the FSM to
    // IDLE, so WE_bar (decoded from state) rises at once and cuts any write.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_data  <= w_data_next;
            r_last  <= w_last_next;
            r_count <= w_count_next;
        end
    end

    // Next-state and datapath update. Writing stops at the top address so a
    // session never wraps back onto address 0.
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_data_next  = r_data;
        w_last_next  = r_last;
        w_count_next = r_count;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_LOAD;
                    w_addr_next  = c_addr_zero;
                    w_count_next = '0;
                end
            end
            S_LOAD: begin
                // in_ready is high throughout LOAD, so in_valid alone marks a transfer
                if (in_valid) begin
                    w_data_next  = in_data;
                    w_last_next  = in_last;
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_count_next = r_count + c_count_one;
                if (r_last || (r_addr == c_addr_max)) begin
                    w_state_next = S_DONE;
                end else begin
                    w_addr_next  = r_addr + c_addr_one;
                    w_state_next = S_LOAD;
                end
            end
            S_DONE: begin
                w_addr_next  = c_addr_zero;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registered state: no input-to-output path.
    always_comb begin
        in_ready    = (r_state == S_LOAD);
        WE_bar      = (r_state != S_WRITE);
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DONE);
        RAM_address = r_addr;
        RAM_data    = r_data;
        word_count  = r_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_loader
//  Description : Self-checking bench for ram_loader. Drives load sessions
//                with random data and handshake gaps, and records every
//                write strobe. The results are compared against the
//                expected write list for each session.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_loader;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [3:0] RAM_address;
    logic [7:0] RAM_data;
    logic       WE_bar;
    logic       busy;
    logic       done;
    logic [4:0] word_count;

    ram_loader #(.WordSize(8), .AddressSize(4)) dut (
        .CLK(CLK), .CLR(CLR), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .RAM_address(RAM_address), .RAM_data(RAM_data),
        .WE_bar(WE_bar), .busy(busy), .done(done), .word_count(word_count)
    );

    always #5 CLK = ~CLK;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    logic [3:0] wr_addr[$];
    logic [7:0] wr_data[$];
    bit         prev_we_low = 1'b0;
    int         done_cnt    = 0;

    logic [7:0] words[32];
    bit         lasts[32];
    int         nwords;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and record what the DUT shows there.
    task automatic tick();
        @(negedge CLK);
        cyc++;
        if (!WE_bar) begin
            check("ready_in_write", in_ready, 0);
            check("we_back_to_back", prev_we_low, 0);
            wr_addr.push_back(RAM_address);
            wr_data.push_back(RAM_data);
        end
        prev_we_low = !WE_bar;
        if (done) begin
            done_cnt++;
            check("ready_in_done", in_ready, 0);
        end
    endtask

    task automatic check_reset_state();
        check("rst_we_bar", WE_bar, 1);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_done", done, 0);
        check("rst_address", RAM_address, 0);
        check("rst_data", RAM_data, 0);
        check("rst_count", word_count, 0);
    endtask

    // One load session. duty = percent chance the source offers a word when
    // idle; noise = pulse start while busy; abort_at = assert CLR during the
    // n-th write strobe (0 = never).
    task automatic run_session(input int duty, input bit noise, input int abort_at);
        int  k;
        int  idx;
        int  accepted;
        int  accept_cyc;
        bit  offering;
        bit  aborted;
        // Reference: the session writes words in order up to and including the
        // first one flagged last, capped at the memory depth of 16.
        k = nwords;
        for (int i = nwords - 1; i >= 0; i--) if (lasts[i]) k = i + 1;
        if (k > 16) k = 16;

        wr_addr.delete();
        wr_data.delete();
        done_cnt   = 0;
        idx        = 0;
        accepted   = 0;
        accept_cyc = -100;
        offering   = 1'b0;
        aborted    = 1'b0;

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (done_cnt > 0) break;
            if (!offering && idx < nwords && ($urandom_range(99) < duty)) offering = 1'b1;
            in_valid = offering;
            if (offering) begin
                in_data = words[idx];
                in_last = lasts[idx];
            end else begin
                in_data = 8'($urandom);
                in_last = 1'($urandom);
            end
            start = noise && busy && !done && ($urandom_range(3) == 0);
            if (offering && in_ready) begin
                accepted++;
                accept_cyc = cyc;
                offering   = 1'b0;
                idx++;
            end
            tick();
            if (abort_at != 0 && !WE_bar && wr_addr.size() == abort_at) begin
                CLR = 1'b1;
                #1;
                check_reset_state();
                in_valid = 1'b0;
                start    = 1'b0;
                tick();
                CLR = 1'b0;
                aborted = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        if (aborted) return;

        check("session_ended", done_cnt, 1);
        check("done_latency", cyc - accept_cyc, 2);
        tick();
        check("done_single_pulse", done_cnt, 1);
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 0);
        check("idle_address", RAM_address, 0);
        check("word_count", word_count, k);
        check("accepted_words", accepted, k);
        check("num_writes", wr_addr.size(), k);
        for (int i = 0; i < k && i < wr_addr.size(); i++) begin
            check("write_addr", wr_addr[i], i);
            check("write_data", wr_data[i], words[i]);
        end
        // word_count must hold through IDLE
        tick();
        check("count_hold", word_count, k);
    endtask

    task automatic set_list(input int n);
        nwords = n;
        for (int i = 0; i < 32; i++) begin
            words[i] = 8'($urandom);
            lasts[i] = 1'b0;
        end
    endtask

    initial begin
        CLR = 1'b1;
        #1;
        check_reset_state();
        repeat (2) @(negedge CLK);
        CLR = 1'b0;
        tick();

        // Basic load
        set_list(4);
        words[0] = 8'h1E; words[1] = 8'h2F; words[2] = 8'hE0; words[3] = 8'hF0;
        lasts[3] = 1'b1;
        run_session(100, 1'b0, 0);

        // Full memory: 20 words, no last flag
        set_list(20);
        for (int i = 0; i < 20; i++) words[i] = 8'(i);
        run_session(100, 1'b0, 0);

        // Single word
        set_list(1);
        words[0] = 8'hA5;
        lasts[0] = 1'b1;
        run_session(100, 1'b0, 0);

        // Random data with 50% source gaps
        for (int s = 0; s < 6; s++) begin
            set_list(20);
            for (int i = 0; i < 20; i++) lasts[i] = ($urandom_range(5) == 0);
            run_session(50, 1'b0, 0);
        end

        // Reset during the 3rd write, then a fresh session from address 0
        set_list(5);
        lasts[4] = 1'b1;
        run_session(100, 1'b0, 3);
        check_reset_state();
        set_list(3);
        lasts[2] = 1'b1;
        run_session(100, 1'b0, 0);

        // start pulses while busy must be ignored
        for (int s = 0; s < 3; s++) begin
            set_list(5);
            lasts[4] = 1'b1;
            run_session((s == 0) ? 100 : 50, 1'b1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
